// File: rtl/preimage_enum_01ee.sv
// Purpose: streams every 4-bit input vector whose 01ee output equals the target; the sweep visits vectors in Gray-code order.
// Latency: one vector per cycle, plus one EMIT cycle per match, plus one DONE cycle at the end.
// Backpressure: a match holds out_vec/out_valid/out_last stable until out_ready.
module preimage_enum_01ee #(
  parameter int N_IN  = 4,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             target,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_IN-1:0]  out_vec,
  output logic             out_last,
  output logic             done,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] toggle_count
);

  localparam int NV = 1 << N_IN;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [N_IN-1:0] idx;
  logic [N_IN-1:0] gray;
  logic            target_q;
  logic            prev_f;
  logic            f_g;
  logic            hit;
  logic            last_idx;
  logic [NV-1:0]   match_mask;
  logic [NV-1:0]   later_mask;

  function automatic logic f_eval(input logic [N_IN-1:0] v);
    return v[0] ^ (v[3] & v[2] & (v[0] | v[1]));
  endfunction

  assign gray     = idx ^ (idx >> 1);
  assign f_g      = f_eval(gray);
  assign hit      = (f_g == target_q);
  assign last_idx = (idx == N_IN'(NV - 1));

  // Bit i is set when Gray position i matches the target; shifting drops positions up to idx.
  always_comb begin
    match_mask = '0;
    for (int i = 0; i < NV; i++) begin
      match_mask[i] = (f_eval(N_IN'(i) ^ (N_IN'(i) >> 1)) == target_q);
    end
  end

  assign later_mask = match_mask >> ({1'b0, idx} + (N_IN + 1)'(1));

  assign busy      = (state != IDLE);
  assign out_valid = (state == EMIT);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: begin
        if (hit)           state_nxt = EMIT;
        else if (last_idx) state_nxt = DONE;
      end
      EMIT: if (out_ready) state_nxt = last_idx ? DONE : SCAN;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx          <= '0;
      target_q     <= 1'b0;
      prev_f       <= 1'b0;
      out_vec      <= '0;
      out_last     <= 1'b0;
      match_count  <= '0;
      toggle_count <= '0;
    end else if (abort) begin
      // Counts stay frozen so the partial sweep remains observable.
      out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            target_q     <= target;
            idx          <= '0;
            prev_f       <= 1'b0;
            match_count  <= '0;
            toggle_count <= '0;
            out_last     <= 1'b0;
          end
        end
        SCAN: begin
          if ((idx != '0) && (f_g != prev_f)) toggle_count <= toggle_count + CNT_W'(1);
          prev_f <= f_g;
          if (hit) begin
            out_vec     <= gray;
            out_last    <= ~|later_mask;
            match_count <= match_count + CNT_W'(1);
          end else if (!last_idx) begin
            idx <= idx + N_IN'(1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_last <= 1'b0;
            if (!last_idx) idx <= idx + N_IN'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_preimage_enum_01ee.sv
// Directed bench for preimage_enum_01ee: a Gray-order model builds the expected stream and counts,
// and a negedge monitor checks every handshake and every done pulse against that model.
module tb_preimage_enum_01ee;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       target;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_vec;
  logic       out_last;
  logic       done;
  logic [4:0] match_count;
  logic [4:0] toggle_count;

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_q[$];
  int         exp_mc;
  int         exp_tc;

  logic       hold_q = 1'b0;
  logic [3:0] hold_vec;
  logic [3:0] e;

  preimage_enum_01ee dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .target(target),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .out_last(out_last), .done(done), .match_count(match_count), .toggle_count(toggle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic f_ref(input logic [3:0] v);
    return v[0] ^ (v[3] & v[2] & (v[0] | v[1]));
  endfunction

  // Walk the sweep in Gray order: matches in visit order, output transitions between neighbours.
  task automatic model_load(input logic t);
    logic [3:0] g;
    logic       pf;
    exp_q.delete();
    exp_tc = 0;
    pf = 1'b0;
    for (int k = 0; k < 16; k++) begin
      g = 4'(k) ^ (4'(k) >> 1);
      if (k != 0 && f_ref(g) != pf) exp_tc++;
      pf = f_ref(g);
      if (f_ref(g) == t) exp_q.push_back(g);
    end
    exp_mc = exp_q.size();
  endtask

  task automatic model_pin();
    logic [3:0] lit1 [7] = '{4'd1, 4'd3, 4'd7, 4'd5, 4'd14, 4'd11, 4'd9};
    logic [3:0] lit0 [9] = '{4'd0, 4'd2, 4'd6, 4'd4, 4'd12, 4'd13, 4'd15, 4'd10, 4'd8};
    model_load(1'b1);
    chk("model_mc_t1", exp_mc, 7);
    chk("model_tc_t1", exp_tc, 8);
    for (int i = 0; i < 7 && i < exp_q.size(); i++) chk("model_seq_t1", exp_q[i], lit1[i]);
    model_load(1'b0);
    chk("model_mc_t0", exp_mc, 9);
    chk("model_tc_t0", exp_tc, 8);
    for (int i = 0; i < 9 && i < exp_q.size(); i++) chk("model_seq_t0", exp_q[i], lit0[i]);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (hold_q) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_vec", out_vec, hold_vec);
    end
    hold_q   = rst_n && !abort && out_valid && !out_ready;
    hold_vec = out_vec;
    if (rst_n && !abort && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_vec: got %0d, expected no further vector", out_vec);
      end else begin
        e = exp_q.pop_front();
        chk("out_vec", out_vec, e);
        chk("out_last", out_last, exp_q.size() == 0);
      end
    end
    if (rst_n && done) begin
      chk("done_match_count", match_count, exp_mc);
      chk("done_toggle_count", toggle_count, exp_tc);
      chk("done_stream_left", exp_q.size(), 0);
    end
  end

  task automatic run_sweep(input logic t, input int stall, input bit mid, input int exp_lat, input int exp_mcl);
    int n;
    int st;
    bit got;
    model_load(t);
    @(posedge clk); #1;
    start = 1'b1; target = t; out_ready = (stall == 0);
    @(posedge clk); #1;
    start = 1'b0; target = ~t;
    n = 1; st = 0; got = 1'b0;
    while (!got && n < 200) begin
      if (done) begin
        got = 1'b1;
        chk("done_latency", n, exp_lat);
        chk("final_match_count", match_count, exp_mcl);
        chk("final_toggle_count", toggle_count, 8);
      end else begin
        start = (mid && n == 10);
        if (stall > 0 && !out_ready && out_valid) begin
          st++;
          if (st > stall) begin
            chk("stall_vec", out_vec, 1);
            out_ready = 1'b1;
          end
        end
        @(posedge clk); #1;
        n++;
      end
    end
    if (!got) chk("done_timeout", n, exp_lat);
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    bit found;
    int dn;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; target = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_vec", out_vec, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_mc", match_count, 0);
    chk("rst_tc", toggle_count, 0);
    rst_n = 1'b1;
    model_pin();

    run_sweep(1'b1, 0, 1'b0, 24, 7);
    run_sweep(1'b0, 0, 1'b0, 26, 9);
    run_sweep(1'b1, 5, 1'b0, 29, 7);
    run_sweep(1'b1, 0, 1'b1, 24, 7);

    // Abort while vector 7 is being offered.
    model_load(1'b1);
    @(posedge clk); #1; start = 1'b1; target = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (out_valid && out_vec == 4'd7) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("abort_reached_7", found, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_mc", match_count, 3);
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      dn += done;
      @(posedge clk); #1;
    end
    chk("abort_no_done", dn, 0);
    exp_q.delete();
    run_sweep(1'b1, 0, 1'b0, 24, 7);

    // Abort wins over a simultaneous start.
    @(posedge clk); #1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_mc", match_count, 7);

    // One-cycle reset mid-sweep.
    model_load(1'b1);
    @(posedge clk); #1; start = 1'b1; target = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_vec", out_vec, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_mc", match_count, 0);
    chk("mid_rst_tc", toggle_count, 0);
    run_sweep(1'b1, 0, 1'b0, 24, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
